alu_stage: RTL

- Execute-stage ALU of the multi-cycle datapath. Sits directly downstream of the operand-B select mux.
- Consumes `readData1` (operand A) and `saidaMux2` (operand B, either register or immediate) together with control fields. Produces a registered result, a zero flag and a branch decision for the memory/writeback and PC-select stages.
- Shares the global 10-phase schedule: it captures one phase after operand B is latched upstream.

---
 rtl/alu_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_stage.sv
// Execute-stage ALU on the shared 10-phase schedule. Operands are sampled once per schedule period.
// Outputs load on the edge where cont == CAPTURE_PHASE and resultValid pulses for one cycle after it; there is no backpressure.
module alu_stage #(
  parameter int CAPTURE_PHASE = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  aluOp,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] readData1,
  input  logic [31:0] saidaMux2,
  output logic [31:0] aluResult,
  output logic        zero,
  output logic        branchTaken,
  output logic        resultValid
);

  localparam logic [3:0] LAST_PHASE = 4'd9;
  localparam logic [3:0] CAP_PHASE  = 4'(CAPTURE_PHASE);

  typedef enum logic [3:0] {
    FN_ADD,
    FN_SUB,
    FN_SLL,
    FN_SLT,
    FN_SLTU,
    FN_XOR,
    FN_SRL,
    FN_SRA,
    FN_OR,
    FN_AND
  } alu_fn_e;

  logic [3:0]  cont_q, cont_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        zero_q, zero_d;
  logic        branch_taken_q, branch_taken_d;
  logic        result_valid_q, result_valid_d;

  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic        alt;
  logic        capture;
  alu_fn_e     fn;
  logic [31:0] sum, diff, calc;
  logic        eq, lt_s, lt_u;
  logic        branch_calc;
  logic        unused_funct7;

  assign op_a          = readData1;
  assign op_b          = saidaMux2;
  assign shamt         = op_b[4:0];
  assign alt           = funct7[5];
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign capture       = (cont_q == CAP_PHASE);

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign eq   = (op_a == op_b);
  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  // Immediate-form arithmetic has no subtract, so funct7[5] only picks SUB for R-type.
  always_comb begin
    fn = FN_ADD;
    case (aluOp)
      2'b00: fn = FN_ADD;
      2'b01: fn = FN_SUB;
      default: begin
        case (funct3)
          3'b000:  fn = (alt && (aluOp == 2'b10)) ? FN_SUB : FN_ADD;
          3'b001:  fn = FN_SLL;
          3'b010:  fn = FN_SLT;
          3'b011:  fn = FN_SLTU;
          3'b100:  fn = FN_XOR;
          3'b101:  fn = alt ? FN_SRA : FN_SRL;
          3'b110:  fn = FN_OR;
          default: fn = FN_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    calc = sum;
    case (fn)
      FN_ADD:  calc = sum;
      FN_SUB:  calc = diff;
      FN_SLL:  calc = op_a << shamt;
      FN_SLT:  calc = {31'd0, lt_s};
      FN_SLTU: calc = {31'd0, lt_u};
      FN_XOR:  calc = op_a ^ op_b;
      FN_SRL:  calc = op_a >> shamt;
      FN_SRA:  calc = $unsigned($signed(op_a) >>> shamt);
      FN_OR:   calc = op_a | op_b;
      FN_AND:  calc = op_a & op_b;
      default: calc = sum;
    endcase
  end

  always_comb begin
    branch_calc = 1'b0;
    if (aluOp == 2'b01) begin
      case (funct3)
        3'b000:  branch_calc = eq;
        3'b001:  branch_calc = !eq;
        3'b100:  branch_calc = lt_s;
        3'b101:  branch_calc = !lt_s;
        3'b110:  branch_calc = lt_u;
        3'b111:  branch_calc = !lt_u;
        default: branch_calc = 1'b0;
      endcase
    end
  end

  always_comb begin
    cont_d         = (cont_q == LAST_PHASE) ? 4'd0 : cont_q + 4'd1;
    alu_result_d   = alu_result_q;
    zero_d         = zero_q;
    branch_taken_d = branch_taken_q;
    result_valid_d = 1'b0;
    if (capture) begin
      alu_result_d   = calc;
      zero_d         = (calc == 32'd0);
      branch_taken_d = branch_calc;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q         <= 4'd0;
      alu_result_q   <= 32'd0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      cont_q         <= cont_d;
      alu_result_q   <= alu_result_d;
      zero_q         <= zero_d;
      branch_taken_q <= branch_taken_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign aluResult   = alu_result_q;
  assign zero        = zero_q;
  assign branchTaken = branch_taken_q;
  assign resultValid = result_valid_q;

endmodule
